iis_tx_sched: RTL and testbench

IIS_TX_SCHED -- requirements
Module: iis_tx_sched

---
 rtl/iis_tx_sched_if.sv | 15 +
 rtl/iis_tx_sched.sv | 139 +++++++++++++
 tb/tb_iis_tx_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iis_tx_sched_if.sv
// Frame-push and serializer handshake bundle for the IIS transmit scheduler.
interface iis_tx_sched_if;
  logic        push_valid;
  logic [15:0] push_l;
  logic [15:0] push_r;
  logic        push_ready;
  logic        word_done;
  logic [2:0]  send_ctrl;
  logic [15:0] data_out;

  modport master (output push_valid, push_l, push_r, word_done,
                  input  push_ready, send_ctrl, data_out);
  modport slave  (input  push_valid, push_l, push_r, word_done,
                  output push_ready, send_ctrl, data_out);
endinterface

// File: rtl/iis_tx_sched.sv
// IIS transmit scheduler: stereo-frame FIFO feeding a serializer one word at a time,
// with underrun/timeout sticky flags and a per-frame interrupt pulse.
module iis_tx_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk_in,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   clr_flags,
  iis_tx_sched_if.slave          bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   timeout_err,
  output logic                   frame_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_L, S_SEND_L, S_LOAD_R, S_SEND_R} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_lword, r_hold;
  logic [TW-1:0] r_tcnt;
  logic          r_busy, r_underrun, r_timeout_err, r_frame_irq;
  logic          w_push, w_pop, w_empty, w_in_send, w_tmo;
  logic [31:0]   w_head;
  logic [2:0]    w_ctrl;
  logic [15:0]   w_data;

  assign w_empty   = (r_level == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_push    = bus.push_valid && bus.push_ready;
  assign w_pop     = (r_state == S_LOAD_L) && !w_empty;
  assign w_in_send = (r_state == S_SEND_L) || (r_state == S_SEND_R);
  // A word_done arriving on the last allowed cycle still counts as on time.
  assign w_tmo     = w_in_send && !bus.word_done && (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_ctrl = 3'b000;
    w_data = '0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_LOAD_L;
      end
      S_LOAD_L: begin
        w_ctrl = 3'b111;
        w_data = w_pop ? w_head[31:16] : '0;
        w_next = S_SEND_L;
      end
      S_SEND_L: begin
        w_ctrl = 3'b011;
        w_data = r_lword;
        if (bus.word_done) w_next = S_LOAD_R;
        else if (w_tmo)    w_next = S_IDLE;
      end
      S_LOAD_R: begin
        w_ctrl = 3'b101;
        w_data = r_hold;
        w_next = S_SEND_R;
      end
      S_SEND_R: begin
        w_ctrl = 3'b001;
        w_data = r_hold;
        if (bus.word_done) w_next = enable ? S_LOAD_L : S_IDLE;
        else if (w_tmo)    w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_tcnt      <= '0;
      r_frame_irq <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_frame_irq <= (r_state == S_SEND_R) && bus.word_done;
      if (w_next != r_state) r_tcnt <= '0;
      else if (w_in_send)    r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_underrun    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == S_LOAD_L) && w_empty) r_underrun <= 1'b1;
      else if (clr_flags)                   r_underrun <= 1'b0;
      if (w_tmo)          r_timeout_err <= 1'b1;
      else if (clr_flags) r_timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_lword  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_state == S_LOAD_L) begin
        r_lword <= w_pop ? w_head[31:16] : '0;
        r_hold  <= w_pop ? w_head[15:0]  : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.push_l, bus.push_r};
  end

  assign bus.push_ready = (r_level != LW'(DEPTH));
  assign bus.send_ctrl  = w_ctrl;
  assign bus.data_out   = w_data;
  assign busy           = r_busy;
  assign level          = r_level;
  assign underrun       = r_underrun;
  assign timeout_err    = r_timeout_err;
  assign frame_irq      = r_frame_irq;
endmodule

// File: tb/tb_iis_tx_sched.sv
// Bench for iis_tx_sched: a frame queue model predicts every word, flag and level.
module tb_iis_tx_sched;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1023;

  logic clk_in = 1'b0, rstn = 1'b0, enable = 1'b0, clr_flags = 1'b0;
  logic busy, underrun, timeout_err, frame_irq;
  logic [$clog2(DEPTH):0] level;
  iis_tx_sched_if bus();

  iis_tx_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rstn(rstn), .enable(enable), .clr_flags(clr_flags), .bus(bus),
    .busy(busy), .level(level), .underrun(underrun), .timeout_err(timeout_err),
    .frame_irq(frame_irq));

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mq[$];

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // Offer one frame; the model accepts it only if it has room.
  task automatic push_frame(input logic [31:0] f);
    bus.push_valid = 1'b1; bus.push_l = f[31:16]; bus.push_r = f[15:0];
    if (mq.size() < DEPTH) mq.push_back(f);
    step();
    bus.push_valid = 1'b0;
  endtask

  // Acts as the serializer for one frame starting from LOAD_L; returns what it saw.
  task automatic serve_frame(input int dl, input int dr, input bit drop_en, input bit ld_push,
                             input logic [31:0] ld_frame, input bit ld_clr,
                             output logic [15:0] ol, output logic [15:0] orr,
                             output logic [11:0] ctrl, output logic irq, output bit bad);
    int w;
    w = 0; bad = 1'b0;
    while (bus.send_ctrl !== 3'b111 && w < 20) begin step(); w++; end
    if (bus.send_ctrl !== 3'b111) bad = 1'b1;
    ctrl[11:9] = bus.send_ctrl; ol = bus.data_out;
    if (ld_push) begin
      bus.push_valid = 1'b1; bus.push_l = ld_frame[31:16]; bus.push_r = ld_frame[15:0];
    end
    clr_flags = ld_clr;
    step();
    bus.push_valid = 1'b0; clr_flags = 1'b0;
    ctrl[8:6] = bus.send_ctrl;
    if (drop_en) enable = 1'b0;
    repeat (dl) step();
    bus.word_done = 1'b1; step(); bus.word_done = 1'b0;
    ctrl[5:3] = bus.send_ctrl; orr = bus.data_out;
    step();
    ctrl[2:0] = bus.send_ctrl;
    repeat (dr) step();
    bus.word_done = 1'b1; step(); bus.word_done = 1'b0;
    irq = frame_irq;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (bus.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got=%0h exp=1", bus.push_ready); end
    n_checks++; if (bus.send_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_send_ctrl got=%b exp=000", bus.send_ctrl); end
    n_checks++; if (bus.data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data_out got=%h exp=0000", bus.data_out); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%0h exp=0", underrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got=%0h exp=0", timeout_err); end
    n_checks++; if (frame_irq !== 1'b0) begin n_fail++; $display("FAIL reset_frame_irq got=%0h exp=0", frame_irq); end
    rstn = 1'b1;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_without_enable busy got=%0h exp=0", busy); end
    bus.word_done = 1'b1; step(); bus.word_done = 1'b0; step();
    n_checks++; if ({busy, frame_irq, bus.send_ctrl} !== 5'b0) begin
      n_fail++; $display("FAIL idle_word_done_ignored got busy=%0h irq=%0h ctrl=%b exp=0,0,000", busy, frame_irq, bus.send_ctrl);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] e; logic [15:0] ol, orr; logic [11:0] c; logic irq; bit bad;
    push_frame(32'h1234ABCD);
    n_checks++; if (level !== 1) begin n_fail++; $display("FAIL single_level_before got=%0d exp=1", level); end
    enable = 1'b1; step();
    e = mq.pop_front();
    serve_frame(5, 5, 1'b1, 1'b0, 32'h0, 1'b0, ol, orr, c, irq, bad);
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL single_load_wait got=timeout exp=LOAD_L"); end
    n_checks++; if (c !== 12'b111_011_101_001) begin n_fail++; $display("FAIL single_ctrl_seq got=%b exp=111011101001", c); end
    n_checks++; if ({ol, orr} !== e) begin n_fail++; $display("FAIL single_words got=%h exp=%h", {ol, orr}, e); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq got=%0h exp=1", irq); end
    n_checks++; if (level !== 0) begin n_fail++; $display("FAIL single_level_after got=%0d exp=0", level); end
    step();
    n_checks++; if ({frame_irq, busy, bus.send_ctrl} !== 5'b0) begin
      n_fail++; $display("FAIL single_end_idle got irq=%0h busy=%0h ctrl=%b exp=0,0,000", frame_irq, busy, bus.send_ctrl);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] e, f; logic [15:0] ol, orr; logic [11:0] c; logic irq; bit bad;
    enable = 1'b1; step();
    serve_frame(2, 3, 1'b1, 1'b0, 32'h0, 1'b1, ol, orr, c, irq, bad);
    n_checks++; if ({bad, ol, orr} !== 33'h0) begin n_fail++; $display("FAIL underrun_words got=%h bad=%0h exp=00000000", {ol, orr}, bad); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set_wins got=%0h exp=1", underrun); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL underrun_irq got=%0h exp=1", irq); end
    step(); clr_flags = 1'b1; step(); clr_flags = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear got=%0h exp=1'b0", underrun); end
    f = $urandom;
    enable = 1'b1; step();
    serve_frame(1, 1, 1'b1, 1'b1, f, 1'b0, ol, orr, c, irq, bad);
    mq.push_back(f);
    n_checks++; if ({ol, orr} !== 32'h0 || underrun !== 1'b1) begin
      n_fail++; $display("FAIL pop_push_empty got words=%h ur=%0h exp=00000000,1", {ol, orr}, underrun);
    end
    n_checks++; if (level !== 1) begin n_fail++; $display("FAIL pop_push_empty_level got=%0d exp=1", level); end
    step(); clr_flags = 1'b1; step(); clr_flags = 1'b0;
    enable = 1'b1; step();
    e = mq.pop_front();
    serve_frame(0, 0, 1'b1, 1'b0, 32'h0, 1'b0, ol, orr, c, irq, bad);
    n_checks++; if ({ol, orr} !== e || underrun !== 1'b0) begin
      n_fail++; $display("FAIL concurrent_push_frame got=%h ur=%0h exp=%h,0", {ol, orr}, underrun, e);
    end
    step();
  endtask

  task automatic test_fill_and_wrap();
    logic [31:0] e; logic [15:0] ol, orr; logic [11:0] c; logic irq; bit bad;
    for (int i = 0; i < DEPTH; i++) push_frame($urandom);
    n_checks++; if (level !== DEPTH || bus.push_ready !== 1'b0) begin
      n_fail++; $display("FAIL full got level=%0d ready=%0h exp=%0d,0", level, bus.push_ready, DEPTH);
    end
    push_frame($urandom);
    n_checks++; if (level !== DEPTH) begin n_fail++; $display("FAIL full_push_ignored got=%0d exp=%0d", level, DEPTH); end
    for (int pass = 0; pass < 2; pass++) begin
      int nf;
      nf = (pass == 0) ? DEPTH : 2;
      if (pass == 1) begin
        push_frame($urandom); push_frame($urandom);
        n_checks++; if (level !== 2) begin n_fail++; $display("FAIL wrap_level got=%0d exp=2", level); end
      end
      enable = 1'b1; step();
      for (int i = 0; i < nf; i++) begin
        e = mq.pop_front();
        serve_frame($urandom_range(0, 6), $urandom_range(0, 6), i == nf - 1, 1'b0, 32'h0, 1'b0,
                    ol, orr, c, irq, bad);
        n_checks++; if (bad || {ol, orr} !== e || irq !== 1'b1) begin
          n_fail++; $display("FAIL fifo_order pass=%0d frame=%0d got=%h irq=%0h exp=%h,1", pass, i, {ol, orr}, irq, e);
        end
      end
      step();
      n_checks++; if (busy !== 1'b0 || level !== 0) begin
        n_fail++; $display("FAIL drain_end pass=%0d got busy=%0h level=%0d exp=0,0", pass, busy, level);
      end
    end
  endtask

  task automatic test_timeout();
    int n; bit irq_seen;
    push_frame($urandom);
    enable = 1'b1; step(); enable = 1'b0;
    void'(mq.pop_front());
    step();
    n = 0; irq_seen = 1'b0;
    while (bus.send_ctrl === 3'b011 && n < TIMEOUT + 20) begin
      n++; step();
      if (frame_irq === 1'b1) irq_seen = 1'b1;
    end
    n_checks++; if (n !== TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TIMEOUT); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%0h exp=1", timeout_err); end
    n_checks++; if ({busy, bus.send_ctrl, irq_seen} !== 5'b0) begin
      n_fail++; $display("FAIL timeout_idle got busy=%0h ctrl=%b irq=%0h exp=0,000,0", busy, bus.send_ctrl, irq_seen);
    end
    n_checks++; if (level !== 0) begin n_fail++; $display("FAIL timeout_level got=%0d exp=0", level); end
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got=%0h exp=0", timeout_err); end
  endtask

  task automatic test_enable_drop_and_reset();
    logic [31:0] e; logic [15:0] ol, orr; logic [11:0] c; logic irq; bit bad;
    push_frame($urandom);
    enable = 1'b1; step();
    e = mq.pop_front();
    serve_frame(3, 3, 1'b1, 1'b0, 32'h0, 1'b0, ol, orr, c, irq, bad);
    n_checks++; if (bad || c !== 12'b111_011_101_001 || {ol, orr} !== e || irq !== 1'b1) begin
      n_fail++; $display("FAIL enable_drop_frame got ctrl=%b words=%h irq=%0h exp=111011101001,%h,1", c, {ol, orr}, irq, e);
    end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_idle got=%0h exp=0", busy); end
    push_frame($urandom); push_frame($urandom);
    enable = 1'b1; step(); step();
    bus.word_done = 1'b1; step(); bus.word_done = 1'b0; step();
    n_checks++; if (bus.send_ctrl !== 3'b001) begin n_fail++; $display("FAIL pre_reset_send_r got=%b exp=001", bus.send_ctrl); end
    rstn = 1'b0; #2;
    mq.delete();
    n_checks++; if ({bus.send_ctrl, bus.data_out, busy, frame_irq, underrun, timeout_err} !== 23'h0 ||
                    level !== 0 || bus.push_ready !== 1'b1) begin
      n_fail++; $display("FAIL midframe_reset got ctrl=%b data=%h busy=%0h level=%0d ready=%0h exp=000,0000,0,0,1",
                         bus.send_ctrl, bus.data_out, busy, level, bus.push_ready);
    end
    enable = 1'b0; step(); rstn = 1'b1; step();
  endtask

  task automatic test_random();
    logic [31:0] e; logic [15:0] ol, orr; logic [11:0] c; logic irq; bit bad, exp_ur;
    for (int it = 0; it < 25; it++) begin
      int np, nf;
      np = $urandom_range(0, 5);
      for (int j = 0; j < np; j++) push_frame($urandom);
      n_checks++; if (level !== mq.size() || bus.push_ready !== (mq.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_level it=%0d got=%0d ready=%0h exp=%0d", it, level, bus.push_ready, mq.size());
      end
      nf = $urandom_range(1, 3); exp_ur = 1'b0;
      enable = 1'b1; step();
      for (int j = 0; j < nf; j++) begin
        if (mq.size() == 0) begin e = 32'h0; exp_ur = 1'b1; end
        else e = mq.pop_front();
        serve_frame($urandom_range(0, 6), $urandom_range(0, 6), j == nf - 1, 1'b0, 32'h0, 1'b0,
                    ol, orr, c, irq, bad);
        n_checks++; if (bad || {ol, orr} !== e || irq !== 1'b1 || c !== 12'b111_011_101_001) begin
          n_fail++; $display("FAIL rand_frame it=%0d f=%0d got=%h ctrl=%b irq=%0h exp=%h", it, j, {ol, orr}, c, irq, e);
        end
      end
      step();
      n_checks++; if (busy !== 1'b0 || underrun !== exp_ur) begin
        n_fail++; $display("FAIL rand_end it=%0d got busy=%0h ur=%0h exp=0,%0h", it, busy, underrun, exp_ur);
      end
      clr_flags = 1'b1; step(); clr_flags = 1'b0;
    end
  endtask

  initial begin
    bus.push_valid = 1'b0; bus.push_l = '0; bus.push_r = '0; bus.word_done = 1'b0;
    test_reset();
    test_single_frame();
    test_underrun();
    test_fill_and_wrap();
    test_timeout();
    test_enable_drop_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
